// File: rtl/measure_ctrl.sv
// measure_ctrl: sequencer for the frequency-measurement datapath.
// Arms the gate, captures the datapath result strobe, optionally doubles the
// gate time on weak signals, and publishes tagged results through a one-deep
// valid/ready buffer with sticky timeout/overrun flags.
module measure_ctrl #(
  parameter int unsigned MIN_SIG_CNT = 1000,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        cont_i,
  input  logic        auto_range_i,
  input  logic [31:0] gate_time_i,
  input  logic [31:0] gate_time_max_i,
  input  logic [31:0] timeout_i,
  input  logic        meas_wr_en_i,
  input  logic [95:0] meas_wr_data_i,
  output logic        gate_en_o,
  output logic [31:0] gate_time_o,
  output logic        busy_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [95:0] res_data_o,
  output logic        timeout_o,
  output logic        overrun_o
);

  localparam logic [31:0] MIN_SIG  = 32'(MIN_SIG_CNT);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_EVAL,
    S_GAP
  } state_e;

  state_e      state_q,     state_d;
  logic        cont_q,      cont_d;
  logic        auto_q,      auto_d;
  logic [31:0] gate_time_q, gate_time_d;
  logic        gate_en_q,   gate_en_d;
  logic [31:0] tmo_cnt_q,   tmo_cnt_d;
  logic [31:0] gap_cnt_q,   gap_cnt_d;
  logic [63:0] meas_q,      meas_d;
  logic        res_valid_q, res_valid_d;
  logic [95:0] res_data_q,  res_data_d;
  logic        timeout_q,   timeout_d;
  logic        overrun_q,   overrun_d;

  logic [31:0] gate_clamped;
  logic [32:0] gate_doubled;
  logic [31:0] gate_next_range;
  logic        retry;
  logic        buf_free;

  // Gate-time arithmetic: start clamp, saturating doubling, retry decision.
  always_comb begin
    gate_clamped    = (gate_time_i > gate_time_max_i) ? gate_time_max_i : gate_time_i;
    gate_doubled    = {gate_time_q, 1'b0};
    gate_next_range = (gate_doubled > {1'b0, gate_time_max_i}) ? gate_time_max_i
                                                                : gate_doubled[31:0];
    retry           = auto_q && (meas_q[31:0] < MIN_SIG) && (gate_time_q < gate_time_max_i);
    buf_free        = !res_valid_q || res_ready_i;
  end

  // Next-state logic for the sequencer and the result buffer.
  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    auto_d      = auto_q;
    gate_time_d = gate_time_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    meas_d      = meas_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;

    // Consumer drain; a publish in EVAL below may reload the same cycle.
    if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end

    // Stop aborts everything in flight (including an EVAL publish) but
    // leaves the already-buffered result untouched.
    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d     = S_ARM;
            cont_d      = cont_i;
            auto_d      = auto_range_i;
            gate_time_d = gate_clamped;
            timeout_d   = 1'b0;
            overrun_d   = 1'b0;
            tmo_cnt_d   = '0;
          end
        end
        S_ARM: begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
          if (meas_wr_en_i) begin
            state_d = S_EVAL;
            meas_d  = meas_wr_data_i[63:0];
          end else if ((timeout_i != '0) && (tmo_cnt_q == timeout_i)) begin
            timeout_d = 1'b1;
            gap_cnt_d = '0;
            state_d   = cont_q ? S_GAP : S_IDLE;
          end
        end
        S_EVAL: begin
          gap_cnt_d = '0;
          if (retry) begin
            gate_time_d = gate_next_range;
            state_d     = S_GAP;
          end else begin
            if (buf_free) begin
              res_valid_d = 1'b1;
              res_data_d  = {gate_time_q, meas_q};
            end else begin
              overrun_d = 1'b1;
            end
            state_d = cont_q ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          tmo_cnt_d = '0;
          if (gap_cnt_q == GAP_LAST) begin
            state_d = S_ARM;
          end else begin
            gap_cnt_d = gap_cnt_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Registered gate enable: high exactly while the sequencer sits in ARM.
    gate_en_d = (state_d == S_ARM);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cont_q      <= 1'b0;
      auto_q      <= 1'b0;
      gate_time_q <= '0;
      gate_en_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      meas_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      auto_q      <= auto_d;
      gate_time_q <= gate_time_d;
      gate_en_q   <= gate_en_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      meas_q      <= meas_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign gate_en_o   = gate_en_q;
  assign gate_time_o = gate_time_q;
  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign timeout_o   = timeout_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_measure_ctrl.sv
// Self-checking bench for measure_ctrl: expected results are queued by the
// stimulus, a negedge monitor pops and compares on every accepted result.
module tb_measure_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        cont;
  logic        auto_range;
  logic [31:0] gate_time;
  logic [31:0] gate_time_max;
  logic [31:0] timeout;
  logic        meas_wr_en;
  logic [95:0] meas_wr_data;
  logic        gate_en;
  logic [31:0] gate_time_out;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [95:0] res_data;
  logic        timeout_flag;
  logic        overrun_flag;

  int tests;
  int failed;
  logic [95:0] exp_q[$];

  measure_ctrl #(
    .MIN_SIG_CNT(1000),
    .GAP_CYCLES (2)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .stop_i         (stop),
    .cont_i         (cont),
    .auto_range_i   (auto_range),
    .gate_time_i    (gate_time),
    .gate_time_max_i(gate_time_max),
    .timeout_i      (timeout),
    .meas_wr_en_i   (meas_wr_en),
    .meas_wr_data_i (meas_wr_data),
    .gate_en_o      (gate_en),
    .gate_time_o    (gate_time_out),
    .busy_o         (busy),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .timeout_o      (timeout_flag),
    .overrun_o      (overrun_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL result_unexpected: got %h expected none", res_data);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        if (res_data !== e) begin
          failed++;
          $display("FAIL result_data: got %h expected %h", res_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle result strobe; upper word is junk the DUT must ignore.
  task automatic strobe(input logic [31:0] cc, input logic [31:0] sc);
    meas_wr_en   = 1'b1;
    meas_wr_data = {32'hA5A5_A5A5, cc, sc};
    tick();
    meas_wr_en   = 1'b0;
    meas_wr_data = '0;
  endtask

  // Ticks until gate_en is high, bounded; returns number of ticks taken.
  task automatic wait_gate(output int n);
    n = 0;
    while (!gate_en && n < 40) begin
      tick();
      n++;
    end
    if (!gate_en) begin
      tests++;
      failed++;
      $display("FAIL wait_gate: got gate_en=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  logic [31:0] ar_sig  [4] = '{32'd10, 32'd10, 32'd10, 32'd5000};
  logic [31:0] ar_gate [4] = '{32'd100, 32'd200, 32'd400, 32'd800};

  initial begin
    int n;
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cont = 1'b0;
    auto_range = 1'b0;
    gate_time = 32'd100;
    gate_time_max = 32'd1000;
    timeout = '0;
    meas_wr_en = 1'b0;
    meas_wr_data = '0;
    res_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_gate_en", 96'(gate_en), 96'(0));
    check("rst_gate_time", 96'(gate_time_out), 96'(0));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_res_valid", 96'(res_valid), 96'(0));
    check("rst_res_data", res_data, 96'(0));
    check("rst_flags", 96'({timeout_flag, overrun_flag}), 96'(0));
    rst_n = 1'b1;
    tick();

    // Single shot: {0,500,2000} -> {100,500,2000}, result 2 cycles after strobe
    do_start();
    check("single_gate_en", 96'(gate_en), 96'(1));
    check("single_gate_time", 96'(gate_time_out), 96'(100));
    check("single_busy", 96'(busy), 96'(1));
    exp_q.push_back({32'd100, 32'd500, 32'd2000});
    strobe(32'd500, 32'd2000);
    check("single_eval_gate_en", 96'(gate_en), 96'(0));
    check("single_eval_busy", 96'(busy), 96'(1));
    check("single_eval_valid", 96'(res_valid), 96'(0));
    tick();
    check("single_done_busy", 96'(busy), 96'(0));
    check("single_done_gate_en", 96'(gate_en), 96'(0));
    check("single_valid", 96'(res_valid), 96'(1));
    tick();
    check("single_drained", 96'(res_valid), 96'(0));

    // Auto-range: gate 100 -> 200 -> 400 -> 800, result tagged 800.
    // Each retry shows gate_en low for EVAL (1) + GAP (2) = 3 cycles.
    auto_range = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ar_gate_%0d", i), 96'(gate_time_out), 96'(ar_gate[i]));
      if (i == 3) exp_q.push_back({32'd800, 32'd77, ar_sig[i]});
      strobe(32'd77, ar_sig[i]);
      if (i < 3) begin
        wait_gate(n);
        check($sformatf("ar_low_cycles_%0d", i), 96'(n), 96'(3));
      end
    end
    tick();
    check("ar_done_busy", 96'(busy), 96'(0));
    tick();
    auto_range = 1'b0;

    // Clamp at start
    gate_time = 32'd2000;
    gate_time_max = 32'd1500;
    do_start();
    check("clamp_gate_time", 96'(gate_time_out), 96'(1500));
    do_stop();
    check("clamp_stop_busy", 96'(busy), 96'(0));

    // Saturating doubling
    gate_time = 32'h9000_0000;
    gate_time_max = 32'hFFFF_FFFF;
    auto_range = 1'b1;
    do_start();
    check("sat_gate_start", 96'(gate_time_out), 96'(32'h9000_0000));
    strobe(32'd1, 32'd10);
    tick();
    check("sat_gate_doubled", 96'(gate_time_out), 96'(32'hFFFF_FFFF));
    do_stop();
    auto_range = 1'b0;
    gate_time = 32'd100;
    gate_time_max = 32'd1000;

    // Timeout: counter starts at 0 in the first ARM cycle and fires when it
    // equals 50, so gate_en is high for 51 cycles.
    timeout = 32'd50;
    do_start();
    n = 1;
    while (gate_en && n < 200) begin
      tick();
      if (gate_en) n++;
    end
    check("tmo_arm_cycles", 96'(n), 96'(51));
    check("tmo_flag", 96'(timeout_flag), 96'(1));
    check("tmo_idle", 96'(busy), 96'(0));

    // Strobe on the cycle the timeout would fire: result wins, flag cleared by start
    do_start();
    check("tmo_flag_cleared", 96'(timeout_flag), 96'(0));
    for (int i = 0; i < 50; i++) tick();
    check("tmo_still_arm", 96'(gate_en), 96'(1));
    exp_q.push_back({32'd100, 32'd9, 32'd3000});
    strobe(32'd9, 32'd3000);
    tick();
    check("tmo_race_flag", 96'(timeout_flag), 96'(0));
    check("tmo_race_valid", 96'(res_valid), 96'(1));
    tick();
    timeout = '0;

    // Continuous, ready=0: first held; ready during second EVAL -> no overrun;
    // third with ready=0 -> dropped, overrun, second held.
    cont = 1'b1;
    res_ready = 1'b0;
    do_start();
    exp_q.push_back({32'd100, 32'd11, 32'd1111});
    strobe(32'd11, 32'd1111);
    tick();
    check("ovr_first_valid", 96'(res_valid), 96'(1));
    wait_gate(n);
    check("ovr_first_held", res_data, {32'd100, 32'd11, 32'd1111});
    strobe(32'd22, 32'd2222);
    res_ready = 1'b1;
    exp_q.push_back({32'd100, 32'd22, 32'd2222});
    tick();
    res_ready = 1'b0;
    check("ovr_none", 96'(overrun_flag), 96'(0));
    check("ovr_second_loaded", res_data, {32'd100, 32'd22, 32'd2222});
    wait_gate(n);
    strobe(32'd33, 32'd3333);
    tick();
    check("ovr_flag", 96'(overrun_flag), 96'(1));
    check("ovr_second_held", res_data, {32'd100, 32'd22, 32'd2222});
    do_stop();
    check("ovr_stop_busy", 96'(busy), 96'(0));
    check("ovr_stop_kept", 96'(res_valid), 96'(1));
    res_ready = 1'b1;
    tick();
    check("ovr_drained", 96'(res_valid), 96'(0));
    cont = 1'b0;

    // Stop mid-ARM with a buffered result; later strobe ignored; start+stop stays idle
    res_ready = 1'b0;
    do_start();
    exp_q.push_back({32'd100, 32'd7, 32'd70});
    strobe(32'd7, 32'd70);
    tick();
    do_start();
    check("stop_pre_gate_en", 96'(gate_en), 96'(1));
    do_stop();
    check("stop_gate_en", 96'(gate_en), 96'(0));
    check("stop_busy", 96'(busy), 96'(0));
    strobe(32'd8, 32'd80);
    tick();
    check("stop_kept_valid", 96'(res_valid), 96'(1));
    check("stop_kept_data", res_data, {32'd100, 32'd7, 32'd70});
    check("stop_ignored_busy", 96'(busy), 96'(0));
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("startstop_busy", 96'(busy), 96'(0));
    check("startstop_gate_en", 96'(gate_en), 96'(0));
    res_ready = 1'b1;
    tick();
    tick();
    check("scoreboard_empty", 96'(exp_q.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
